// File: rtl/pattern_line_generator_if.sv
// Line-buffer write port of the pattern line generator.
//
// Handshake: the master holds write_enable high while it has a pixel on
// write_address/write_data. A beat transfers on a rising clock edge where
// write_enable and write_ready are both high. While write_ready is low, the
// master keeps address and data stable. write_ready may toggle freely and
// never depends combinationally on write_enable.
//
// Signals:
//   write_enable  master -> slave  write request
//   write_ready   slave  -> master line buffer accepts a write this cycle
//   write_address master -> slave  {bank bit, x}
//   write_data    master -> slave  per channel {R,G,B}, channel 0 in MSBs
interface pattern_line_generator_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 48
);
  logic              write_enable;
  logic              write_ready;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output write_enable,
    output write_address,
    output write_data,
    input  write_ready
  );

  modport slave (
    input  write_enable,
    input  write_address,
    input  write_data,
    output write_ready
  );
endinterface

// File: rtl/pattern_line_generator.sv
// Pattern line generator: on a start request, writes one scan row of a test
// pattern (bars, gradient, scrolling bars or checkerboard) into a line buffer,
// one pixel per accepted write beat, then pulses done.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   y            scan row to generate (latched on start)
//   frame_count  frame number; low XW bits latched on start, used by scroll mode
//   mode         0 bars, 1 gradient, 2 scroll, 3 checker (latched on start)
//   start        request one row; only looked at in IDLE
//   is_idle      high only in IDLE
//   done         one-cycle pulse after the last pixel of a row transferred
//   state_dbg_o  current FSM state (IDLE=0, RUN=1, DONE=2)
//   wr           line-buffer write port (master side)
module pattern_line_generator #(
  parameter int WIDTH      = 64,
  parameter int ROW_BITS   = 5,
  parameter int COLOR_BITS = 8,
  parameter int CHANNELS   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ROW_BITS-1:0] y,
  input  logic [9:0]          frame_count,
  input  logic [1:0]          mode,
  input  logic                start,
  output logic                is_idle,
  output logic                done,
  output logic [1:0]          state_dbg_o,
  pattern_line_generator_if.master wr
);

  localparam int XW    = $clog2(WIDTH);
  // Row identifier {channel, y}; two channels need only one channel bit.
  localparam int RW    = (CHANNELS <= 2) ? ROW_BITS + 1 : ROW_BITS + 2;
  localparam int PIX_W = 3 * COLOR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [ROW_BITS-1:0] y_q, y_d;
  logic [1:0]          mode_q, mode_d;
  logic [XW-1:0]       fc_q, fc_d;

  // Only the low XW bits of the frame number matter for a WIDTH-pixel scroll.
  logic unused_fc_hi;
  assign unused_fc_hi = ^frame_count[9:XW];

  // Colour-bar colours: R, G, B follow x bits 0, 1, 2.
  function automatic logic [PIX_W-1:0] bars(input logic [XW-1:0] v);
    return {{COLOR_BITS{v[0]}}, {COLOR_BITS{v[1]}}, {COLOR_BITS{v[2]}}};
  endfunction

  // ---------------------------------------------------------------------
  // FSM state register and row context
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      fc_q    <= fc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    fc_d    = fc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = '0;
          y_d     = y;
          mode_d  = mode;
          fc_d    = frame_count[XW-1:0];
        end
      end
      S_RUN: begin
        // write_enable is high throughout RUN, so ready alone marks a beat.
        if (wr.write_ready) begin
          x_d = x_q + 1'b1;  // wraps to 0 after the last pixel
          if (x_q == XW'(WIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign is_idle          = (state_q == S_IDLE);
  assign done             = (state_q == S_DONE);
  assign state_dbg_o      = state_q;
  assign wr.write_enable  = (state_q == S_RUN);
  assign wr.write_address = {y_q[0], x_q};

  // ---------------------------------------------------------------------
  // Pixel colour generation (purely from registered row context and x)
  // ---------------------------------------------------------------------
  logic [XW-1:0]            xs;
  logic [XW+3:0]            x_ext;      // zero-extended so bit 3 always exists
  logic [COLOR_BITS+XW-1:0] x_shift;    // x left-aligned in a colour
  logic [1:0]               chan;
  logic [RW-1:0]            row_c;
  logic [RW+3:0]            row_ext;
  logic [COLOR_BITS+RW-1:0] row_shift;  // row_c left-aligned in a colour
  logic                     chk;
  logic [PIX_W-1:0]         pix;

  always_comb begin
    wr.write_data = '0;
    xs            = x_q + fc_q;  // mod WIDTH by width truncation
    x_ext         = {4'b0, x_q};
    x_shift       = {x_q, {COLOR_BITS{1'b0}}};
    chan          = '0;
    row_c         = '0;
    row_ext       = '0;
    row_shift     = '0;
    chk           = 1'b0;
    pix           = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan      = 2'(c);
      row_c     = RW'({chan, y_q});
      row_ext   = {4'b0, row_c};
      row_shift = {row_c, {COLOR_BITS{1'b0}}};
      chk       = x_ext[3] ^ row_ext[3];
      unique case (mode_q)
        2'd0: pix = bars(x_q);
        2'd1: pix = {x_shift[COLOR_BITS+XW-1 -: COLOR_BITS],
                     row_shift[COLOR_BITS+RW-1 -: COLOR_BITS],
                     {COLOR_BITS{1'b0}}};
        2'd2: pix = bars(xs);
        default: pix = {PIX_W{chk}};
      endcase
      wr.write_data[(CHANNELS-1-c)*PIX_W +: PIX_W] = pix;
    end
  end

endmodule

// File: tb/tb_pattern_line_generator.sv
// Bench for pattern_line_generator (WIDTH=64, ROW_BITS=5, COLOR_BITS=8,
// CHANNELS=2). Each row pushes its 64 expected {address, data} words when
// start is driven; a negedge monitor pops one per accepted beat.
module tb_pattern_line_generator;

  localparam int WIDTH = 64;
  localparam int DW    = 48;
  localparam int AW    = 7;
  localparam int EW    = AW + DW;

  logic       clock;
  logic       reset;
  logic [4:0] y;
  logic [9:0] frame_count;
  logic [1:0] mode;
  logic       start;
  logic       is_idle;
  logic       done;
  logic [1:0] state_dbg;

  pattern_line_generator_if #(.ADDR_W(AW), .DATA_W(DW)) wr_if ();

  logic write_ready;
  assign wr_if.write_ready = write_ready;

  pattern_line_generator #(
    .WIDTH(WIDTH), .ROW_BITS(5), .COLOR_BITS(8), .CHANNELS(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .y           (y),
    .frame_count (frame_count),
    .mode        (mode),
    .start       (start),
    .is_idle     (is_idle),
    .done        (done),
    .state_dbg_o (state_dbg),
    .wr          (wr_if.master)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] cap_data [WIDTH];
  logic [AW-1:0] cap_addr [WIDTH];
  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference pixel word: {bank, x, ch0 RGB, ch1 RGB}.
  function automatic logic [EW-1:0] exp_word(input int m, input int yy, input int fc, input int x);
    logic [DW-1:0] d;
    logic [7:0] r, g, b;
    int xs, rc, v;
    d = '0;
    for (int c = 0; c < 2; c++) begin
      rc = c * 32 + yy;
      r = 8'h00; g = 8'h00; b = 8'h00;
      case (m)
        0, 2: begin
          xs = (m == 2) ? (x + fc) % 64 : x;
          r = (xs % 2 != 0)       ? 8'hFF : 8'h00;
          g = ((xs / 2) % 2 != 0) ? 8'hFF : 8'h00;
          b = ((xs / 4) % 2 != 0) ? 8'hFF : 8'h00;
        end
        1: begin
          r = 8'((x * 4) % 256);
          g = 8'((rc * 4) % 256);
          b = 8'h00;
        end
        default: begin
          v = ((x / 8) % 2) ^ ((rc / 8) % 2);
          r = (v != 0) ? 8'hFF : 8'h00;
          g = r;
          b = r;
        end
      endcase
      d = {d[23:0], r, g, b};
    end
    return {1'(yy % 2), 6'(x), d};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (!reset && wr_if.write_enable) begin
      if (write_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_if.write_address, e[EW-1 -: AW]);
          check("wr_data", wr_if.write_data, e[DW-1:0]);
          cap_addr[e[DW+5:DW]] = wr_if.write_address;
          cap_data[e[DW+5:DW]] = wr_if.write_data;
        end
        xfers++;
      end else if (exp_q.size() != 0) begin
        check("stall_addr", wr_if.write_address, exp_q[0][EW-1 -: AW]);
        check("stall_data", wr_if.write_data, exp_q[0][DW-1:0]);
      end
    end
    if (!reset && done) done_cnt++;
  end

  // ---------------- driver ----------------
  // stall_x / stray_x / rst_x: pixel index at which to hold ready low for 3
  // cycles, pulse a stray start, or assert reset; -1 disables.
  task automatic run_row(input int m, input int yy, input int fc, input int stall_x,
                         input int stray_x, input int rst_x, input int exp_lat,
                         input string tag);
    int lat, stalls;
    bit fin, stray_done;
    check({tag, "_idle_before"}, is_idle, 1);
    xfers = 0; done_cnt = 0; lat = 0; stalls = 0; fin = 0; stray_done = 0;
    for (int x = 0; x < WIDTH; x++) exp_q.push_back(exp_word(m, yy, fc, x));
    mode = 2'(m); y = 5'(yy); frame_count = 10'(fc); start = 1'b1; write_ready = 1'b1;
    while (!fin) begin
      @(posedge clock); #1;
      lat++;
      start = 1'b0;
      // Inputs wander mid-row; only the latched values may matter.
      mode = 2'($urandom_range(0, 3));
      y = 5'($urandom_range(0, 31));
      frame_count = 10'($urandom_range(0, 1023));
      if (done) begin
        fin = 1;
        check({tag, "_latency"}, lat, exp_lat);
      end else if (lat > 400) begin
        check({tag, "_timeout"}, 0, 1);
        exp_q.delete();
        fin = 1;
      end else if (xfers == rst_x) begin
        reset = 1'b1; #1;
        check({tag, "_rst_idle"}, is_idle, 1);
        check({tag, "_rst_we"}, wr_if.write_enable, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_addr"}, wr_if.write_address, 0);
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        fin = 1;
      end else begin
        if (xfers == stray_x && !stray_done) begin
          start = 1'b1;
          stray_done = 1;
        end
        write_ready = !(xfers == stall_x && stalls < 3);
        if (!write_ready) stalls++;
      end
    end
    if (rst_x < 0) begin
      @(posedge clock); #1;  // DONE -> IDLE
    end
    check({tag, "_done_pulses"}, done_cnt, (rst_x < 0) ? 1 : 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    start = 1'b0;
    write_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; y = 5'd0; frame_count = 10'd0;
    write_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_is_idle", is_idle, 1);
    check("rst_done", done, 0);
    check("rst_we", wr_if.write_enable, 0);
    check("rst_addr", wr_if.write_address, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Bars, odd row: bank bit 1, addresses 0x40..0x7F.
    run_row(0, 3, 0, -1, -1, -1, 65, "bars");
    check("bars_addr_first", cap_addr[0], 7'h40);
    check("bars_addr_last", cap_addr[63], 7'h7F);
    check("bars_x5", cap_data[5], 48'hFF00FF_FF00FF);

    // Gradient, y=2.
    run_row(1, 2, 0, -1, -1, -1, 65, "grad");
    check("grad_x63", cap_data[63], 48'hFC0800_FC8800);

    // Scroll by frame 0x3C5 (offset 5).
    run_row(2, 9, 'h3C5, -1, -1, -1, 65, "scroll");
    check("scroll_x0", cap_data[0], 48'hFF00FF_FF00FF);
    check("scroll_x59", cap_data[59], 48'h0);

    // Checker with a 3-cycle stall at x=10.
    run_row(3, 7, 0, 10, -1, -1, 68, "stall");

    // Stray start at x=20, then a row started in the IDLE right after DONE.
    run_row(0, 4, 0, -1, 20, -1, 65, "stray");
    run_row(1, 17, 0, -1, -1, -1, 65, "b2b");

    // Reset at x=30, then a fresh row must begin at x=0.
    run_row(2, 21, 'h123, -1, -1, 30, 0, "abort");
    run_row(3, 12, 0, -1, -1, -1, 65, "after_rst");
    check("after_rst_x0_addr", cap_addr[0], 7'h00);

    // A few random rows with a stall somewhere.
    for (int i = 0; i < 3; i++) begin
      run_row($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 1023),
              $urandom_range(0, 63), -1, -1, 68, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_line_generator.md
PATTERN_LINE_GENERATOR -- requirements
Module: pattern_line_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 64, pixels per row; power of two, 8..256; XW = log2(WIDTH).
REQ-002 SHALL have parameter ROW_BITS, default 5, scan-row index width; ROW_BITS+1 <= COLOR_BITS.
REQ-003 SHALL have parameter COLOR_BITS, default 8, bits per colour component; XW <= COLOR_BITS.
REQ-004 SHALL have parameter CHANNELS, default 2, panel halves driven per row, 1..4.
REQ-005 SHALL have port clock  input  1  clock, rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port y  input  ROW_BITS  scan row to generate.
REQ-008 SHALL have port frame_count  input  10  frame number, used by scroll mode.
REQ-009 SHALL have port mode  input  2  pattern: 0 bars, 1 gradient, 2 scroll, 3 checker.
REQ-010 SHALL have port start  input  1  request one row; sampled only in IDLE.
REQ-011 SHALL have port write_ready  input  1  line buffer accepts a write this cycle.
REQ-012 SHALL have port is_idle  output  1  high only in IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after row complete.
REQ-014 SHALL have port write_address  output  XW+1  {bank bit, x}.
REQ-015 SHALL have port write_data  output  CHANNELS*3*COLOR_BITS  per channel {R,G,B}; channel 0 in MSBs.
REQ-016 SHALL have port write_enable  output  1  write request.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE.
REQ-018 SHALL go IDLE->RUN on start in IDLE, latching y, mode and frame_count[XW-1:0]; x counter SHALL be 0.
REQ-019 SHALL hold write_enable high for every cycle in RUN, low in IDLE and DONE.
REQ-020 SHALL count a transfer only when write_enable and write_ready are both high; x increments by 1 per transfer.
REQ-021 SHALL hold x, write_address and write_data stable while write_ready is low (stall).
REQ-022 SHALL go RUN->DONE on the transfer with x = WIDTH-1, then DONE->IDLE next cycle, x wrapping to 0.
REQ-023 SHALL assert done only in DONE; exactly WIDTH transfers per row.
REQ-024 SHALL ignore start in RUN and DONE; start in the IDLE cycle following DONE SHALL be accepted.
REQ-025 SHALL drive write_address = {latched y[0], x}, combinational from registered state.
REQ-026 SHALL define row_c = {c, latched y} (c = channel index, ROW_BITS+2 bits, truncated to ROW_BITS+1 for CHANNELS<=2).
REQ-027 Mode 0 SHALL output R = all x[0], G = all x[1], B = all x[2] (each bit replicated COLOR_BITS times), all channels.
REQ-028 Mode 1 SHALL output R = x << (COLOR_BITS-XW), G = row_c left-aligned in COLOR_BITS, B = 0.
REQ-029 Mode 2 SHALL output mode-0 colours computed from xs = (x + latched frame_count[XW-1:0]) mod WIDTH.
REQ-030 Mode 3 SHALL output R = G = B = all (x[3] XOR row_c[3]).
REQ-031 SHALL use only latched mode/y/frame_count during a row; input changes mid-row have no effect.

Reset
REQ-032 On reset SHALL enter IDLE, x = 0, latched registers = 0: is_idle = 1, done = 0, write_enable = 0, write_address = 0.
REQ-033 Reset asserted mid-row SHALL abort immediately; no done pulse; next start restarts at x = 0.

Verification
REQ-034 WIDTH=64, mode 0, y=3, write_ready=1, start pulse -> 64 writes, addresses 0x40..0x7F, x=5 data R=FF,G=00,B=FF both channels, done at cycle 65 after start.
REQ-035 mode 1, y=2, CHANNELS=2 -> at x=63 channel 0 {FC,08,00}, channel 1 {FC,88,00}.
REQ-036 mode 2, frame_count=0x3C5 -> x=0 gives xs=5 colours; x=59 gives xs=0 (all 00).
REQ-037 write_ready low 3 cycles at x=10 -> address/data held at x=10, still exactly 64 transfers, done 3 cycles later.
REQ-038 start pulsed in RUN at x=20 -> ignored, single done; start during DONE-following IDLE -> new row begins.
REQ-039 reset asserted at x=30 -> next cycle is_idle=1, write_enable=0, no done; following start writes x=0 first.
